// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  // FSM encoding; S_IDLE is zero so reset lands in IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DIV_WIDTH = 32;

  // Iteration counter width: wide enough to count 0..w-1 with headroom
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor for one restoring step.
// o_neg is the borrow out, so it is correct over the full unsigned range
// of both operands.
module div_trial_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_neg
);

  logic [WIDTH+1:0] w_full;

  assign w_full = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff = w_full[WIDTH:0];
  assign o_neg  = w_full[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed or unsigned, fixed WIDTH+2 latency.
//
// Handshake: start is a request that is accepted on the rising edge where
// the FSM is in IDLE (busy low); A, B and signed_op are captured on that
// same edge. busy stays high until the edge that leaves DONE. done is a
// one-cycle pulse marking LO/HI/div_by_zero valid; there is no backpressure,
// and the results hold until the next division's FIX cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             div_by_zero,
  output logic [2:0]       o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_dbz;

  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_diff;
  logic             w_neg;
  logic             w_last_iter;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Shifted partial remainder: {R,Q} << 1 keeps the bit leaving Q as R's new LSB
  assign w_part      = {r_r, r_q[WIDTH-1]};
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
  assign w_a_mag     = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_b_mag     = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
  assign w_q_fix     = r_sign_q ? -r_q : r_q;
  assign w_r_fix     = r_sign_r ? -r_r : r_r;

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .i_a    (w_part),
    .i_b    ({1'b0, r_d}),
    .o_diff (w_diff),
    .o_neg  (w_neg)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: w_next = S_ITER;
      S_ITER:  if (w_last_iter) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, magnitude setup, restoring iterations, sign fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_signed <= signed_op;
          end
        end
        S_SETUP: begin
          r_q      <= w_a_mag;
          r_d      <= w_b_mag;
          r_r      <= '0;
          r_cnt    <= '0;
          r_sign_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_sign_r <= r_signed & r_a[WIDTH-1];
        end
        S_ITER: begin
          r_cnt <= r_cnt + CW'(1);
          r_q   <= {r_q[WIDTH-2:0], ~w_neg};
          r_r   <= w_neg ? w_part[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
        S_FIX: begin
          // Divide-by-zero overrides the iteration result entirely
          if (r_b == '0) begin
            r_lo  <= '1;
            r_hi  <= r_a;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= w_q_fix;
            r_hi  <= w_r_fix;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign LO          = r_lo;
  assign HI          = r_hi;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement division, 0 = unsigned division; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
REQ-009 SHALL have port done  output  1  single-cycle pulse; HI and LO are valid while it is high.
REQ-010 SHALL have port LO  output  WIDTH  quotient.
REQ-011 SHALL have port HI  output  WIDTH  remainder.
REQ-012 SHALL have port div_by_zero  output  1  high when the last division had B == 0; valid with done.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ITER, FIX and DONE.
REQ-014 Transitions SHALL be:
- IDLE -> SETUP on start, latching A, B and signed_op.
- SETUP -> ITER after 1 cycle.
- ITER -> FIX after exactly WIDTH cycles.
- FIX -> DONE after 1 cycle.
- DONE -> IDLE after 1 cycle.
REQ-015 Latency SHALL be fixed: done is high in the cycle beginning WIDTH+2 edges after the accepting edge (34 for WIDTH=32), independent of operand values.
REQ-016 start SHALL be ignored in all states other than IDLE; the latched operands SHALL NOT change while busy.
REQ-017 SETUP SHALL:
- convert each operand to its magnitude when signed_op=1, else use it unchanged;
- record sign_q = sign(A) xor sign(B) and sign_r = sign(A);
- clear the remainder register and the iteration counter.
REQ-018 Each ITER cycle SHALL perform one restoring step:
- shift {R,Q} left 1 bit;
- trial = R - D, computed at WIDTH+1 bits;
- if trial is nonnegative, R = trial and Q LSB = 1, else R is kept and Q LSB = 0.
REQ-019 FIX SHALL negate Q when sign_q=1 and negate R when sign_r=1 (signed_op=1 only), then register LO=Q and HI=R.
- Results truncate toward zero; the remainder takes the dividend's sign.
REQ-020 Signed overflow SHALL wrap: -2^(WIDTH-1) / -1 gives LO = 0x80000000 and HI = 0 (for WIDTH=32), div_by_zero=0.
REQ-021 B == 0 SHALL keep the full latency and SHALL give LO = all ones, HI = the original A, and div_by_zero = 1.
REQ-022 LO, HI and div_by_zero SHALL hold their values after done until the FIX of the next division.

Reset
REQ-023 rst SHALL, immediately and in any state, set the FSM to IDLE and clear busy, done, LO, HI, div_by_zero, the counter and all internal registers to 0.
REQ-024 A division interrupted by rst SHALL produce no done pulse; a start on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-025 The shared package SHALL hold:
- the FSM state enum;
- DIV_WIDTH = 32;
- the iteration-counter width, clog2(DIV_WIDTH)+1.
REQ-026 SHALL instantiate exactly one sub-module, div_trial_sub: a combinational WIDTH+1-bit subtractor whose outputs are the difference and a negative flag; all other logic stays in seq_divider.

Verification
REQ-027 Unsigned 7 / 2 -> LO=3, HI=1, div_by_zero=0, done exactly 34 cycles after the accepting edge.
REQ-028 Signed -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-029 Unsigned 0xFFFFFFFF / 1 -> LO=0xFFFFFFFF, HI=0; unsigned 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1, same latency.
REQ-030 start pulsed at cycle 5 of a division with different operands -> ignored; first division's results are unchanged.
REQ-031 rst asserted 10 cycles into ITER -> busy=0, all outputs 0 at once, no done; a following 9 / 3 -> LO=3, HI=0.
REQ-032 Back-to-back: start held high continuously -> a new division is accepted in the IDLE cycle after each DONE; every done pulse is exactly 1 cycle wide.
